// File: rtl/modn_cascade_counter_if.sv
// Control and status bundle for modn_cascade_counter.
// The master drives the count controls; the slave (the counter) returns its value and flags.
interface modn_cascade_counter_if #(
  parameter int unsigned DIGITS = 1,
  parameter int unsigned DW     = 4
);
  logic                 en;
  logic                 up;
  logic                 load;
  logic [DIGITS*DW-1:0] load_val;
  logic [DIGITS*DW-1:0] q;
  logic                 tc;
  logic                 wrap;
  logic                 load_err;

  modport master (
    output en, up, load, load_val,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/modn_cascade_counter.sv
// Multi-digit modulo-RADIX counter with enable, up/down direction, clamped parallel load,
// combinational terminal count and registered wrap / load-error pulses.
module modn_cascade_counter #(
  parameter int unsigned RADIX  = 10,
  parameter int unsigned DIGITS = 1,
  parameter int unsigned DW     = 4
) (
  input logic                   clk,
  input logic                   resetn,
  modn_cascade_counter_if.slave bus
);

  if (RADIX < 2 || ((RADIX - 1) >> DW) != 0) begin : g_bad_radix
    $fatal(1, "modn_cascade_counter: RADIX must lie in 2..2**DW");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $fatal(1, "modn_cascade_counter: DIGITS must lie in 1..8");
  end

  localparam logic [DW-1:0] MaxDigit = DW'(RADIX - 1);

  logic [DIGITS-1:0][DW-1:0] q_q, q_d, q_step, q_load;
  logic                      wrap_q, wrap_d;
  logic                      load_err_q, load_err_d;
  logic [DW-1:0]             term_val;
  logic [DW-1:0]             ld_dig;
  logic                      carry;
  logic                      all_term;
  logic                      clamp;

  // Ripple carry: digit k steps only while every lower digit sits at its terminal value.
  always_comb begin
    term_val = bus.up ? MaxDigit : '0;
    carry    = 1'b1;
    q_step   = q_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (carry) begin
        if (q_q[k] == term_val) begin
          q_step[k] = bus.up ? '0 : MaxDigit;
        end else begin
          q_step[k] = bus.up ? q_q[k] + DW'(1) : q_q[k] - DW'(1);
        end
      end
      carry = carry & (q_q[k] == term_val);
    end
    all_term = carry;
  end

  always_comb begin
    clamp  = 1'b0;
    ld_dig = '0;
    q_load = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      ld_dig = bus.load_val[k*DW +: DW];
      if (ld_dig > MaxDigit) begin
        q_load[k] = MaxDigit;
        clamp     = 1'b1;
      end else begin
        q_load[k] = ld_dig;
      end
    end
  end

  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      q_d        = q_load;
      load_err_d = clamp;
    end else if (bus.en) begin
      q_d    = q_step;
      wrap_d = all_term;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.tc       = bus.en & all_term;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule
